// File: rtl/arith_pkg.sv
// Shared arithmetic-datapath definitions.
// Provides the divider FSM state encoding and the default operand width.
package arith_pkg;

   localparam int unsigned DivWidthDefault = 4;

   typedef enum logic [1:0] {
      StIdle = 2'b00,
      StBusy = 2'b01,
      StDone = 2'b10
   } div_state_e;

endpackage

// File: rtl/borrow_look_ahead_subtractor.sv
// Combinational borrow look-ahead subtractor: diff = minuend - subtrahend - bin.
// Ports:
//   minuend, subtrahend : WIDTH-bit operands
//   bin                 : borrow in
//   diff                : WIDTH-bit difference
//   bout                : borrow out (1 when the result went negative)
module borrow_look_ahead_subtractor #(
   parameter int unsigned WIDTH = 5
) (
   input  logic [WIDTH-1:0] minuend,
   input  logic [WIDTH-1:0] subtrahend,
   input  logic             bin,
   output logic [WIDTH-1:0] diff,
   output logic             bout
);

   logic [WIDTH-1:0] gen;
   logic [WIDTH-1:0] prop;
   logic [WIDTH:0]   borrow;
   logic             acc;
   logic             chain;

   // A bit generates a borrow when a=0,b=1 and passes one through when a==b.
   assign gen  = ~minuend & subtrahend;
   assign prop = ~(minuend ^ subtrahend);

   // Each borrow is a flat sum of products over lower generates, not a ripple.
   always_comb begin
      borrow    = '0;
      acc       = 1'b0;
      chain     = 1'b1;
      borrow[0] = bin;
      for (int i = 1; i <= int'(WIDTH); i++) begin
         acc   = 1'b0;
         chain = 1'b1;
         for (int j = i - 1; j >= 0; j--) begin
            acc   = acc | (chain & gen[j]);
            chain = chain & prop[j];
         end
         borrow[i] = acc | (chain & bin);
      end
   end

   assign diff = minuend ^ subtrahend ^ borrow[WIDTH-1:0];
   assign bout = borrow[WIDTH];

endmodule

// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   start               : launch request, sampled only while idle
//   dividend, divisor   : operands, captured when start is accepted
//   busy                : high while iterating
//   done                : one-cycle pulse when results are updated
//   quotient, remainder : registered results, held until the next done
//   div_by_zero         : set alongside done when the divisor was zero
module seq_restoring_divider
   import arith_pkg::*;
#(
   parameter int unsigned WIDTH = DivWidthDefault
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int unsigned CntW = $clog2(WIDTH + 1);

   div_state_e state_q, state_d;

   logic [WIDTH-1:0] q_q, q_d;      // dividend shifting out, quotient shifting in
   logic [WIDTH-1:0] d_q, d_d;
   logic [WIDTH:0]   r_q, r_d;      // partial remainder
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic [WIDTH-1:0] quot_q, quot_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic             dbz_q, dbz_d;

   logic [WIDTH:0]   r_shift;
   logic [WIDTH:0]   trial;
   logic             trial_borrow;
   logic [WIDTH:0]   r_next;
   logic [WIDTH-1:0] q_next;
   logic             last_iter;

   // R stays below D after every step, so its top bit never survives a shift.
   logic unused_r_msb;
   assign unused_r_msb = r_q[WIDTH];

   assign r_shift   = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
   assign last_iter = (cnt_q == CntW'(1));

   borrow_look_ahead_subtractor #(
      .WIDTH(WIDTH + 1)
   ) u_sub (
      .minuend   (r_shift),
      .subtrahend({1'b0, d_q}),
      .bin       (1'b0),
      .diff      (trial),
      .bout      (trial_borrow)
   );

   // Restore (keep the shifted value) when the trial subtraction underflows.
   assign r_next = trial_borrow ? r_shift : trial;
   assign q_next = {q_q[WIDTH-2:0], ~trial_borrow};

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d = (divisor == '0) ? StDone : StBusy;
            end
         end
         StBusy: begin
            if (last_iter) begin
               state_d = StDone;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Outputs decoded from the registered state only.
   always_comb begin
      busy = (state_q == StBusy);
      done = (state_q == StDone);
   end

   // Datapath next-state.
   always_comb begin
      q_d    = q_q;
      d_d    = d_q;
      r_d    = r_q;
      cnt_d  = cnt_q;
      quot_d = quot_q;
      rem_d  = rem_q;
      dbz_d  = dbz_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               q_d   = dividend;
               d_d   = divisor;
               r_d   = '0;
               cnt_d = CntW'(WIDTH);
               if (divisor == '0) begin
                  quot_d = '1;
                  rem_d  = dividend;
                  dbz_d  = 1'b1;
               end
            end
         end
         StBusy: begin
            q_d   = q_next;
            r_d   = r_next;
            cnt_d = cnt_q - CntW'(1);
            if (last_iter) begin
               quot_d = q_next;
               rem_d  = r_next[WIDTH-1:0];
               dbz_d  = 1'b0;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_q    <= '0;
         d_q    <= '0;
         r_q    <= '0;
         cnt_q  <= '0;
         quot_q <= '0;
         rem_q  <= '0;
         dbz_q  <= 1'b0;
      end else begin
         q_q    <= q_d;
         d_q    <= d_d;
         r_q    <= r_d;
         cnt_q  <= cnt_d;
         quot_q <= quot_d;
         rem_q  <= rem_d;
         dbz_q  <= dbz_d;
      end
   end

   assign quotient    = quot_q;
   assign remainder   = rem_q;
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider (WIDTH=4).
module tb_seq_restoring_divider;

   localparam int W  = 4;
   localparam int TO = 40;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] dividend = '0;
   logic [W-1:0] divisor = '0;
   logic         busy;
   logic         done;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;
   logic         div_by_zero;

   int n_cmp = 0;
   int n_bad = 0;

   seq_restoring_divider #(
      .WIDTH(W)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .dividend   (dividend),
      .divisor    (divisor),
      .busy       (busy),
      .done       (done),
      .quotient   (quotient),
      .remainder  (remainder),
      .div_by_zero(div_by_zero)
   );

   always #5 clk = ~clk;

   function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endfunction

   // Reference model: an accepted request with nonzero divisor finishes W edges
   // later with a/b and a%b; a zero divisor finishes on the accepting edge.
   bit           m_active = 1'b0;
   bit           m_done = 1'b0;
   int           m_t = 0;
   logic [W-1:0] m_q = '0;
   logic [W-1:0] m_r = '0;
   logic         m_z = 1'b0;
   logic [W-1:0] p_q = '0;
   logic [W-1:0] p_r = '0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_active = 1'b0;
         m_done   = 1'b0;
         m_t      = 0;
         m_q      = '0;
         m_r      = '0;
         m_z      = 1'b0;
      end else if (m_done) begin
         m_done = 1'b0;
      end else if (m_active) begin
         m_t++;
         if (m_t == W) begin
            m_active = 1'b0;
            m_done   = 1'b1;
            m_q      = p_q;
            m_r      = p_r;
            m_z      = 1'b0;
         end
      end else if (start) begin
         if (divisor == '0) begin
            m_q    = '1;
            m_r    = dividend;
            m_z    = 1'b1;
            m_done = 1'b1;
         end else begin
            p_q      = dividend / divisor;
            p_r      = dividend % divisor;
            m_active = 1'b1;
            m_t      = 0;
         end
      end
   end

   bit cmp_en = 1'b0;

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("mdl_busy", 32'(busy), 32'(m_active));
         chk("mdl_done", 32'(done), 32'(m_done));
         chk("mdl_quot", 32'(quotient), 32'(m_q));
         chk("mdl_rem", 32'(remainder), 32'(m_r));
         chk("mdl_dbz", 32'(div_by_zero), 32'(m_z));
      end
   end

   // Launch one op and wait (bounded) for done; lat counts negedges after E0.
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] q, output logic [W-1:0] r,
                         output logic z, output int lat);
      @(negedge clk);
      start    = 1'b1;
      dividend = a;
      divisor  = b;
      @(negedge clk);
      start    = 1'b0;
      dividend = 4'($urandom);
      divisor  = 4'($urandom);
      lat = 1;
      while (done !== 1'b1 && lat < TO) begin
         @(negedge clk);
         lat++;
      end
      if (lat >= TO) chk("done_timeout", 32'(done), 32'(1));
      q = quotient;
      r = remainder;
      z = div_by_zero;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      logic [W-1:0] q, r;
      logic         z;
      int           lat;
      int           pulses;

      repeat (2) @(negedge clk);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_quot", 32'(quotient), 0);
      chk("rst_rem", 32'(remainder), 0);
      chk("rst_dbz", 32'(div_by_zero), 0);
      cmp_en = 1'b1;
      rst_n  = 1'b1;

      run_op(4'd13, 4'd3, q, r, z, lat);
      chk("d13_3_quot", 32'(q), 4);
      chk("d13_3_rem", 32'(r), 1);
      chk("d13_3_dbz", 32'(z), 0);
      chk("d13_3_lat", 32'(lat), 5);

      run_op(4'd15, 4'd1, q, r, z, lat);
      chk("d15_1_quot", 32'(q), 15);
      chk("d15_1_rem", 32'(r), 0);
      run_op(4'd2, 4'd9, q, r, z, lat);
      chk("d2_9_quot", 32'(q), 0);
      chk("d2_9_rem", 32'(r), 2);
      repeat (3) @(negedge clk);
      chk("hold_quot", 32'(quotient), 0);
      chk("hold_rem", 32'(remainder), 2);

      run_op(4'd7, 4'd0, q, r, z, lat);
      chk("d7_0_quot", 32'(q), 15);
      chk("d7_0_rem", 32'(r), 7);
      chk("d7_0_dbz", 32'(z), 1);
      chk("d7_0_lat", 32'(lat), 1);
      run_op(4'd8, 4'd2, q, r, z, lat);
      chk("d8_2_quot", 32'(q), 4);
      chk("d8_2_rem", 32'(r), 0);
      chk("d8_2_dbz", 32'(z), 0);

      // A start pulse during BUSY must be ignored.
      @(negedge clk);
      start    = 1'b1;
      dividend = 4'd12;
      divisor  = 4'd5;
      @(negedge clk);
      start  = 1'b0;
      pulses = 0;
      for (int i = 1; i <= 10; i++) begin
         if (i == 2) begin
            start    = 1'b1;
            dividend = 4'd9;
            divisor  = 4'd3;
         end
         if (i == 3) start = 1'b0;
         if (done === 1'b1) begin
            pulses++;
            q = quotient;
            r = remainder;
         end
         @(negedge clk);
      end
      chk("ign_pulses", 32'(pulses), 1);
      chk("ign_quot", 32'(q), 2);
      chk("ign_rem", 32'(r), 2);

      // Asynchronous reset in the middle of an operation.
      start    = 1'b1;
      dividend = 4'd14;
      divisor  = 4'd3;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      chk("pre_rst_busy", 32'(busy), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_busy", 32'(busy), 0);
      chk("arst_done", 32'(done), 0);
      chk("arst_quot", 32'(quotient), 0);
      chk("arst_rem", 32'(remainder), 0);
      chk("arst_dbz", 32'(div_by_zero), 0);
      @(negedge clk);
      rst_n = 1'b1;
      run_op(4'd14, 4'd3, q, r, z, lat);
      chk("d14_3_quot", 32'(q), 4);
      chk("d14_3_rem", 32'(r), 2);
      chk("d14_3_lat", 32'(lat), 5);

      // Exhaustive operand sweep against plain arithmetic.
      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            run_op(4'(a), 4'(b), q, r, z, lat);
            if (b == 0) begin
               chk("sw0_quot", 32'(q), 15);
               chk("sw0_rem", 32'(r), 32'(a));
               chk("sw0_dbz", 32'(z), 1);
               chk("sw0_lat", 32'(lat), 1);
            end else begin
               chk("sw_quot", 32'(q), 32'(a / b));
               chk("sw_rem", 32'(r), 32'(a % b));
               chk("sw_dbz", 32'(z), 0);
               chk("sw_lat", 32'(lat), 5);
            end
         end
      end

      // start held high with operands changing every cycle.
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         start    = 1'b1;
         dividend = 4'($urandom);
         divisor  = 4'($urandom_range(0, 15));
      end
      @(negedge clk);
      start = 1'b0;

      // Random ops with random idle gaps.
      for (int i = 0; i < 60; i++) begin
         repeat ($urandom_range(0, 3)) @(negedge clk);
         run_op(4'($urandom), 4'($urandom_range(0, 15)), q, r, z, lat);
      end

      repeat (4) @(negedge clk);
      cmp_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
